// File: rtl/clk_div_model.sv
// clk_div_model: NCHAN registered clock dividers with enable strobes, emulated
// MMCM lock and reconfig handshake. Option macro: CLK_DIV_FAST_LOCK_EN.
module clk_div_model #(
  parameter int NCHAN       = 4,
  parameter int DIV_W       = 8,
  parameter int LOCK_CYCLES = 64,
  parameter logic [NCHAN*DIV_W-1:0] DIV_INIT = {NCHAN{DIV_W'(2)}}
) (
  input  logic                   clk_in1,
  input  logic                   reset,
  input  logic [NCHAN*DIV_W-1:0] div_cfg,
  input  logic                   cfg_we,
  output logic                   cfg_rdy,
  output logic                   cfg_done,
  output logic [NCHAN-1:0]       clk_out,
  output logic [NCHAN-1:0]       clk_en,
  output logic                   locked
);

`ifdef CLK_DIV_FAST_LOCK_EN
  localparam int L_EFF = (LOCK_CYCLES < 4) ? LOCK_CYCLES : 4;
`else
  localparam int L_EFF = LOCK_CYCLES;
`endif

  localparam int CW = $clog2(LOCK_CYCLES + 1);
  localparam logic [CW-1:0] C_LOCK  = CW'(L_EFF);
  // Reset release counts the release edge itself as the first lock cycle.
  localparam logic [CW-1:0] C_START = CW'((L_EFF >= 2) ? 2 : 0);

  localparam logic [1:0] S_RESET   = 2'd0;
  localparam logic [1:0] S_LOCKING = 2'd1;
  localparam logic [1:0] S_LOCKED  = 2'd2;

  logic [1:0]       r_state;
  logic [CW-1:0]    r_lcnt;
  logic             r_reconf;
  logic             r_done;
  logic [NCHAN-1:0] r_out;
  logic [NCHAN-1:0] r_en;
  logic [DIV_W-1:0] r_div [NCHAN];
  logic [DIV_W-1:0] r_k   [NCHAN];

  logic [DIV_W-1:0] w_d     [NCHAN];
  logic [DIV_W-1:0] w_knext [NCHAN];
  logic [NCHAN-1:0] w_last;
  logic [NCHAN-1:0] w_hi;
  logic [NCHAN-1:0] w_en;
  logic [NCHAN-1:0] w_en0;

  always_comb begin
    for (int i = 0; i < NCHAN; i++) begin
      w_d[i]     = (r_div[i] == '0) ? DIV_W'(1) : r_div[i];
      w_last[i]  = (r_k[i] == w_d[i] - 1'b1);
      w_knext[i] = w_last[i] ? '0 : r_k[i] + 1'b1;
      w_hi[i]    = ({1'b0, w_knext[i]} <
                    (({1'b0, w_d[i]} + 1'b1) >> 1));
      w_en[i]    = (w_knext[i] == w_d[i] - 1'b1);
      w_en0[i]   = (w_d[i] == DIV_W'(1));
    end
  end

  always_ff @(posedge clk_in1) begin
    if (reset) begin
      r_state  <= S_RESET;
      r_lcnt   <= '0;
      r_reconf <= 1'b0;
      r_done   <= 1'b0;
      r_out    <= '0;
      r_en     <= '0;
      for (int i = 0; i < NCHAN; i++) begin
        r_div[i] <= DIV_INIT[i*DIV_W +: DIV_W];
        r_k[i]   <= '0;
      end
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        S_RESET: begin
          r_out <= '0;
          r_en  <= '0;
          if (L_EFF == 1) begin
            r_state <= S_LOCKED;
            r_out   <= '1;
            r_en    <= w_en0;
          end else begin
            r_state <= S_LOCKING;
            r_lcnt  <= C_START;
          end
        end
        S_LOCKING: begin
          r_out <= '0;
          r_en  <= '0;
          if (r_lcnt == C_LOCK) begin
            // All channels start at k=0 together: phase-aligned outputs.
            r_state  <= S_LOCKED;
            r_done   <= r_reconf;
            r_reconf <= 1'b0;
            r_out    <= '1;
            r_en     <= w_en0;
            for (int i = 0; i < NCHAN; i++) r_k[i] <= '0;
          end else begin
            r_lcnt <= r_lcnt + 1'b1;
          end
        end
        S_LOCKED: begin
          if (cfg_we) begin
            r_state  <= S_LOCKING;
            r_lcnt   <= '0;
            r_reconf <= 1'b1;
            r_out    <= '0;
            r_en     <= '0;
            for (int i = 0; i < NCHAN; i++) begin
              r_div[i] <= div_cfg[i*DIV_W +: DIV_W];
              r_k[i]   <= '0;
            end
          end else begin
            r_out <= w_hi;
            r_en  <= w_en;
            for (int i = 0; i < NCHAN; i++) r_k[i] <= w_knext[i];
          end
        end
        default: begin
          r_state <= S_RESET;
          r_out   <= '0;
          r_en    <= '0;
        end
      endcase
    end
  end

  assign locked   = (r_state == S_LOCKED);
  assign cfg_rdy  = locked;
  assign cfg_done = r_done;
  assign clk_out  = r_out;
  assign clk_en   = r_en;

endmodule

// File: tb/tb_clk_div_model.sv
// tb_clk_div_model: random and directed stimulus against an arithmetic
// model of lock timing and k = (edges since lock) mod D.
module tb_clk_div_model;
  localparam int NCHAN       = 4;
  localparam int DIV_W       = 8;
  localparam int LOCK_CYCLES = 64;
`ifdef CLK_DIV_FAST_LOCK_EN
  localparam int LEFF = (LOCK_CYCLES < 4) ? LOCK_CYCLES : 4;
`else
  localparam int LEFF = LOCK_CYCLES;
`endif

  logic                   clk = 1'b0;
  logic                   reset;
  logic [NCHAN*DIV_W-1:0] div_cfg;
  logic                   cfg_we;
  logic                   cfg_rdy;
  logic                   cfg_done;
  logic [NCHAN-1:0]       clk_out;
  logic [NCHAN-1:0]       clk_en;
  logic                   locked;

  always #5 clk = ~clk;

  clk_div_model #(
    .NCHAN(NCHAN), .DIV_W(DIV_W), .LOCK_CYCLES(LOCK_CYCLES),
    .DIV_INIT({NCHAN{8'd2}})
  ) u_dut (
    .clk_in1(clk), .reset(reset), .div_cfg(div_cfg), .cfg_we(cfg_we),
    .cfg_rdy(cfg_rdy), .cfg_done(cfg_done), .clk_out(clk_out),
    .clk_en(clk_en), .locked(locked)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h @edge", tag, got, exp);
    end
  endtask

  int edge_n   = 0;
  bit m_rst    = 1'b1;
  bit m_lock   = 1'b0;
  bit m_reconf = 1'b0;
  bit m_done   = 1'b0;
  int m_tgt    = -1;
  int m_lock_e = 0;
  int m_div [NCHAN];
  int done_cnt = 0;

  function automatic int eff(int d);
    return (d == 0) ? 1 : d;
  endfunction

  task automatic step();
    logic [NCHAN-1:0] e_out;
    logic [NCHAN-1:0] e_en;
    int d;
    int k;
    @(posedge clk);
    edge_n++;
    m_done = 1'b0;
    if (reset) begin
      m_rst    = 1'b1;
      m_lock   = 1'b0;
      m_reconf = 1'b0;
      for (int i = 0; i < NCHAN; i++) m_div[i] = 2;
    end else if (m_rst) begin
      m_rst = 1'b0;
      m_tgt = edge_n + LEFF - 1;
    end else if (m_lock && cfg_we) begin
      for (int i = 0; i < NCHAN; i++) m_div[i] = int'(div_cfg[i*DIV_W +: DIV_W]);
      m_lock   = 1'b0;
      m_reconf = 1'b1;
      m_tgt    = edge_n + 1 + LEFF;
    end
    if (!reset && !m_rst && !m_lock && edge_n == m_tgt) begin
      m_lock   = 1'b1;
      m_lock_e = edge_n;
      m_done   = m_reconf;
      m_reconf = 1'b0;
    end
    e_out = '0;
    e_en  = '0;
    if (m_lock) begin
      for (int i = 0; i < NCHAN; i++) begin
        d = eff(m_div[i]);
        k = (edge_n - m_lock_e) % d;
        e_out[i] = (k < (d + 1) / 2);
        e_en[i]  = (k == d - 1);
      end
    end
    #1;
    if (cfg_done) done_cnt++;
    chk("locked", 32'(locked), 32'(m_lock));
    chk("cfg_rdy", 32'(cfg_rdy), 32'(m_lock));
    chk("cfg_done", 32'(cfg_done), 32'(m_done));
    chk("clk_out", 32'(clk_out), 32'(e_out));
    chk("clk_en", 32'(clk_en), 32'(e_en));
  endtask

  task automatic wait_lock(string tag, input int rel, input int exp_len);
    int c;
    c = 0;
    while (!locked && c < 400) begin
      step();
      c++;
    end
    chk({tag, "_timeout"}, 32'(locked), 32'd1);
    if (exp_len > 0) chk(tag, 32'(edge_n - rel + 1), 32'(exp_len));
  endtask

  int rel;

  initial begin
    reset   = 1'b1;
    cfg_we  = 1'b0;
    div_cfg = '0;
    for (int i = 0; i < NCHAN; i++) m_div[i] = 2;
    repeat (5) step();

    // reset release and lock with DIV_INIT
    reset = 1'b0;
    rel   = edge_n + 1;
    wait_lock("lock_len_rst", rel, LEFF);
    repeat (12) step();

    // mixed ratios
    div_cfg = {8'd5, 8'd3, 8'd1, 8'd0};
    cfg_we  = 1'b1;
    step();
    cfg_we  = 1'b0;
    rel     = edge_n + 1;
    done_cnt = 0;
    repeat (3) step();
    // ignored request during LOCKING
    div_cfg = {8'd9, 8'd9, 8'd9, 8'd9};
    cfg_we  = 1'b1;
    step();
    cfg_we  = 1'b0;
    div_cfg = '0;
    wait_lock("lock_len_cfg", rel, LEFF + 1);
    repeat (40) step();
    chk("done_once", 32'(done_cnt), 32'd1);

    // simultaneous reset and cfg_we
    div_cfg = {8'd4, 8'd6, 8'd7, 8'd3};
    reset   = 1'b1;
    cfg_we  = 1'b1;
    step();
    reset   = 1'b0;
    cfg_we  = 1'b0;
    done_cnt = 0;
    rel     = edge_n + 1;
    wait_lock("lock_len_rst2", rel, LEFF);
    repeat (10) step();
    chk("done_after_rst", 32'(done_cnt), 32'd0);

    // reset mid-period with D=7 at k=3
    div_cfg = {4{8'd7}};
    cfg_we  = 1'b1;
    step();
    cfg_we  = 1'b0;
    wait_lock("lock_d7", 0, 0);
    repeat (3) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    rel   = edge_n + 1;
    wait_lock("lock_len_mid", rel, LEFF);
    repeat (10) step();

    // randomized traffic
    for (int n = 0; n < 1500; n++) begin
      for (int i = 0; i < NCHAN; i++)
        div_cfg[i*DIV_W +: DIV_W] = DIV_W'($urandom_range(0, 12));
      cfg_we = ($urandom_range(0, 15) == 0);
      reset  = ($urandom_range(0, 299) == 0);
      step();
    end
    reset  = 1'b0;
    cfg_we = 1'b0;
    repeat (5) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
